anneal_sweep_ctrl: RTL and testbench

//  Sequences annealing sweeps over the N-row coupling matrix Q. Issues row indices 0..N-1
//  to the spin-update datapath with a valid/ready handshake. Repeats for a programmed number
//  of sweeps and steps a temperature register down once per sweep.

---
 rtl/neurosa_pkg.sv | 15 +
 rtl/temp_sched.sv | 41 ++++
 rtl/anneal_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_anneal_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/neurosa_pkg.sv
// Shared types and sizing helpers for the annealing sweep controller.
package neurosa_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } ctrl_state_t;

    // Row-index width; a one-row matrix still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/temp_sched.sv
// Temperature schedule: loads a start value and step, then steps down with a floor at zero.
module temp_sched #(
    parameter int TEMP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [TEMP_W-1:0] init_i,
    input  logic [TEMP_W-1:0] step_i,
    input  logic              dec_i,
    output logic [TEMP_W-1:0] temp_o
);

    logic [TEMP_W-1:0] temp_q, temp_d;
    logic [TEMP_W-1:0] step_q, step_d;

    always_comb begin
        temp_d = temp_q;
        step_d = step_q;
        if (load_i) begin
            temp_d = init_i;
            step_d = step_i;
        end else if (dec_i) begin
            // Saturate at zero instead of wrapping to a hot temperature.
            temp_d = (temp_q > step_q) ? (temp_q - step_q) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            temp_q <= '0;
            step_q <= '0;
        end else begin
            temp_q <= temp_d;
            step_q <= step_d;
        end
    end

    assign temp_o = temp_q;

endmodule

// File: rtl/anneal_sweep_ctrl.sv
// Issues row indices 0..N-1 per sweep over a valid/ready handshake for a programmed
// number of sweeps, stepping the temperature down once per completed sweep.
module anneal_sweep_ctrl
    import neurosa_pkg::*;
#(
    parameter int N       = 4,
    parameter int SWEEP_W = 16,
    parameter int TEMP_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SWEEP_W-1:0]    num_sweeps,
    input  logic [TEMP_W-1:0]     temp_init,
    input  logic [TEMP_W-1:0]     temp_step,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [$clog2(N)-1:0]  row_idx,
    output logic [TEMP_W-1:0]     temp,
    output logic [SWEEP_W-1:0]    sweep_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam int                 IDX_W    = idx_w(N);
    localparam logic [IDX_W-1:0]   LAST_ROW = IDX_W'(N - 1);

    ctrl_state_t          state_q, state_d;
    logic [IDX_W-1:0]     row_idx_q, row_idx_d;
    logic [SWEEP_W-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic [SWEEP_W-1:0]   num_sweeps_q, num_sweeps_d;
    logic                 row_valid_q, row_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 temp_load;
    logic                 temp_dec;
    logic [SWEEP_W-1:0]   sweep_inc;
    logic                 xfer;

    assign xfer      = row_valid_q & row_ready;
    assign sweep_inc = sweep_cnt_q + SWEEP_W'(1);

    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        sweep_cnt_d  = sweep_cnt_q;
        num_sweeps_d = num_sweeps_q;
        row_valid_d  = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        temp_load    = 1'b0;
        temp_dec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A simultaneous abort suppresses the start.
                if (start && !abort) begin
                    num_sweeps_d = num_sweeps;
                    row_idx_d    = '0;
                    sweep_cnt_d  = '0;
                    temp_load    = 1'b1;
                    if (num_sweeps != '0) begin
                        state_d     = RUN;
                        row_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    row_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    if (xfer) begin
                        if (row_idx_q == LAST_ROW) begin
                            row_idx_d   = '0;
                            sweep_cnt_d = sweep_inc;
                            temp_dec    = 1'b1;
                            if (sweep_inc == num_sweeps_q) begin
                                state_d     = FINISH;
                                row_valid_d = 1'b0;
                                busy_d      = 1'b0;
                                done_d      = 1'b1;
                            end
                        end else begin
                            row_idx_d = row_idx_q + IDX_W'(1);
                        end
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_idx_q    <= '0;
            sweep_cnt_q  <= '0;
            num_sweeps_q <= '0;
            row_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_idx_q    <= row_idx_d;
            sweep_cnt_q  <= sweep_cnt_d;
            num_sweeps_q <= num_sweeps_d;
            row_valid_q  <= row_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    temp_sched #(
        .TEMP_W (TEMP_W)
    ) u_temp_sched (
        .clk    (clk),
        .rst    (rst),
        .load_i (temp_load),
        .init_i (temp_init),
        .step_i (temp_step),
        .dec_i  (temp_dec),
        .temp_o (temp)
    );

    assign row_valid = row_valid_q;
    assign row_idx   = row_idx_q;
    assign sweep_cnt = sweep_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_anneal_sweep_ctrl.sv
// Self-checking bench for anneal_sweep_ctrl against a transfer-indexed reference model.
module tb_anneal_sweep_ctrl;

    localparam int N       = 4;
    localparam int SWEEP_W = 16;
    localparam int TEMP_W  = 8;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [SWEEP_W-1:0]   num_sweeps;
    logic [TEMP_W-1:0]    temp_init;
    logic [TEMP_W-1:0]    temp_step;
    logic                 row_valid;
    logic                 row_ready;
    logic [$clog2(N)-1:0] row_idx;
    logic [TEMP_W-1:0]    temp;
    logic [SWEEP_W-1:0]   sweep_cnt;
    logic                 busy;
    logic                 done;

    int n_asserts = 0;
    int n_fail    = 0;

    anneal_sweep_ctrl #(
        .N       (N),
        .SWEEP_W (SWEEP_W),
        .TEMP_W  (TEMP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_sweeps (num_sweeps),
        .temp_init  (temp_init),
        .temp_step  (temp_step),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_idx    (row_idx),
        .temp       (temp),
        .sweep_cnt  (sweep_cnt),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Temperature after a given number of completed sweeps, floored at zero.
    function automatic int model_temp(input int ti, input int ts, input int sweeps);
        int v;
        v = ti - sweeps * ts;
        return (v < 0) ? 0 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_row_valid"}, 32'(row_valid), 0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_done"},      32'(done),      0);
    endtask

    // One complete run; k counts accepted transfers, from which row/temp/sweep follow.
    task automatic do_run(input int ns, input int ti, input int ts,
                          input bit rnd_ready, input bit poke);
        int k;
        int cyc;
        int limit;
        int fin_temp;
        k        = 0;
        cyc      = 0;
        limit    = 20 * N * ns + 20;
        fin_temp = model_temp(ti, ts, ns);
        num_sweeps = SWEEP_W'(ns);
        temp_init  = TEMP_W'(ti);
        temp_step  = TEMP_W'(ts);
        start      = 1'b1;
        tick();
        start = 1'b0;
        if (ns == 0) begin
            chk("zero_done",      32'(done),      1);
            chk("zero_busy",      32'(busy),      0);
            chk("zero_row_valid", 32'(row_valid), 0);
            chk("zero_sweep_cnt", 32'(sweep_cnt), 0);
            tick();
            chk_idle("zero_after");
        end else begin
            while (k < N * ns && cyc < limit) begin
                chk("run_row_valid", 32'(row_valid), 1);
                chk("run_busy",      32'(busy),      1);
                chk("run_done",      32'(done),      0);
                chk("run_row_idx",   32'(row_idx),   32'(k % N));
                chk("run_temp",      32'(temp),      32'(model_temp(ti, ts, k / N)));
                chk("run_sweep_cnt", 32'(sweep_cnt), 32'(k / N));
                row_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (poke) begin
                    start      = 1'($urandom_range(0, 1));
                    num_sweeps = SWEEP_W'($urandom);
                    temp_init  = TEMP_W'($urandom);
                    temp_step  = TEMP_W'($urandom);
                end
                if (row_ready) k++;
                tick();
                cyc++;
            end
            row_ready = 1'b0;
            start     = 1'b0;
            chk("transfer_count", 32'(k), 32'(N * ns));
            chk("fin_done",      32'(done),      1);
            chk("fin_busy",      32'(busy),      0);
            chk("fin_row_valid", 32'(row_valid), 0);
            chk("fin_sweep_cnt", 32'(sweep_cnt), 32'(ns));
            chk("fin_temp",      32'(temp),      32'(fin_temp));
            if (poke) begin
                start      = 1'b1;
                num_sweeps = SWEEP_W'(3);
            end
            tick();
            start = 1'b0;
            chk_idle("post_fin");
            chk("hold_sweep_cnt", 32'(sweep_cnt), 32'(ns));
            chk("hold_temp",      32'(temp),      32'(fin_temp));
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        num_sweeps = '0;
        temp_init  = '0;
        temp_step  = '0;
        row_ready  = 1'b0;

        #12;
        chk_idle("reset");
        chk("reset_row_idx",   32'(row_idx),   0);
        chk("reset_temp",      32'(temp),      0);
        chk("reset_sweep_cnt", 32'(sweep_cnt), 0);
        rst = 1'b1;
        tick();
        chk_idle("idle");

        // Directed: two sweeps at full throughput, then saturating temperature.
        do_run(2, 10, 3, 1'b0, 1'b0);
        do_run(3, 5, 3, 1'b0, 1'b0);

        // Random backpressure, with start poked while busy and in FINISH.
        do_run(3, 200, 17, 1'b1, 1'b1);
        do_run(0, 44, 4, 1'b0, 1'b0);

        // Abort at row 2 of the second sweep, with a transfer in the abort cycle.
        num_sweeps = SWEEP_W'(3);
        temp_init  = TEMP_W'(100);
        temp_step  = TEMP_W'(7);
        start      = 1'b1;
        tick();
        start     = 1'b0;
        row_ready = 1'b1;
        repeat (6) tick();
        chk("pre_abort_row_idx",   32'(row_idx),   2);
        chk("pre_abort_sweep_cnt", 32'(sweep_cnt), 1);
        chk("pre_abort_temp",      32'(temp),      93);
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        row_ready = 1'b0;
        chk_idle("abort");
        chk("abort_row_idx",   32'(row_idx),   2);
        chk("abort_sweep_cnt", 32'(sweep_cnt), 1);
        chk("abort_temp",      32'(temp),      93);
        repeat (3) begin
            tick();
            chk("abort_no_done", 32'(done), 0);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_idle("start_abort_idle");
        do_run(2, 60, 9, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a run.
        num_sweeps = SWEEP_W'(4);
        temp_init  = TEMP_W'(50);
        temp_step  = TEMP_W'(5);
        start      = 1'b1;
        tick();
        start     = 1'b0;
        row_ready = 1'b1;
        repeat (5) tick();
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_row_idx",   32'(row_idx),   0);
        chk("async_rst_temp",      32'(temp),      0);
        chk("async_rst_sweep_cnt", 32'(sweep_cnt), 0);
        row_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk_idle("after_rst");

        // Randomized runs against the model.
        for (int r = 0; r < 6; r++) begin
            do_run(int'($urandom_range(0, 5)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
